// File: rtl/wrapper_pkg.sv
// Shared definitions for the input/output wrapper controllers:
// handshake state encoding and default frame geometry.
package wrapper_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } wrapper_state_e;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_NWORDS = 4;

endpackage : wrapper_pkg

// File: rtl/output_buffer_reg.sv
// Result holding register: captures a full result on load and
// presents one word of it selected by the word counter.
module output_buffer_reg #(
  parameter int WORD_W = 8,
  parameter int NWORDS = 4,
  parameter int CNT_W  = $clog2(NWORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NWORDS*WORD_W-1:0] din,
  input  logic [CNT_W-1:0]         sel,
  output logic [WORD_W-1:0]        word
);

  logic [NWORDS-1:0][WORD_W-1:0] buf_r;

  // Capture the whole result on load; hold otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_r <= '0;
    end else if (load) begin
      buf_r <= din;
    end else begin
      buf_r <= buf_r;
    end
  end

  assign word = buf_r[sel];

endmodule : output_buffer_reg

// File: rtl/output_wrapper_cntrlr.sv
// Transmit-side wrapper: captures the core result on done and serializes
// it word by word over a four-phase output_rdy/output_acc handshake.
module output_wrapper_cntrlr
  import wrapper_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NWORDS = DEF_NWORDS,
  parameter int CNT_W  = $clog2(NWORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [NWORDS*WORD_W-1:0] result,
  input  logic                     output_acc,
  output logic                     output_rdy,
  output logic [WORD_W-1:0]        dout,
  output logic                     outsent,
  output logic                     busy,
  output logic                     ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  wrapper_state_e   state_r;
  wrapper_state_e   state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cap_s;
  logic             adv_s;
  logic             output_rdy_s;
  logic             outsent_s;
  logic             output_rdy_r;
  logic             outsent_r;
  logic             busy_r;
  logic             ovf_r;

  assign cap_s = (state_r == IDLE) && done;
  assign adv_s = (state_r == RELEASE) && !output_acc && (cnt_r != LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic for the four-phase handshake
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (done) state_next_s = SEND;
        else      state_next_s = IDLE;
      end
      SEND: begin
        if (output_acc) state_next_s = RELEASE;
        else            state_next_s = SEND;
      end
      RELEASE: begin
        if (output_acc)              state_next_s = RELEASE;
        else if (cnt_r == LAST_CNT)  state_next_s = IDLE;
        else                         state_next_s = SEND;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so flags are registered
  always_comb begin
    output_rdy_s = 1'b0;
    outsent_s    = 1'b1;
    case (state_next_s)
      IDLE: begin
        output_rdy_s = 1'b0;
        outsent_s    = 1'b1;
      end
      SEND: begin
        output_rdy_s = 1'b1;
        outsent_s    = 1'b0;
      end
      RELEASE: begin
        output_rdy_s = 1'b0;
        outsent_s    = 1'b0;
      end
      default: begin
        output_rdy_s = 1'b0;
        outsent_s    = 1'b1;
      end
    endcase
  end

  // Handshake flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      output_rdy_r <= 1'b0;
      outsent_r    <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      output_rdy_r <= output_rdy_s;
      outsent_r    <= outsent_s;
      busy_r       <= ~outsent_s;
    end
  end

  // Word counter: restarts only on capture and never wraps
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (cap_s) begin
      cnt_r <= '0;
    end else if (adv_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky overflow: a result arrived while a frame was still in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (done && (state_r != IDLE)) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  output_buffer_reg #(
    .WORD_W (WORD_W),
    .NWORDS (NWORDS),
    .CNT_W  (CNT_W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (cap_s),
    .din  (result),
    .sel  (cnt_r),
    .word (dout)
  );

  assign output_rdy = output_rdy_r;
  assign outsent    = outsent_r;
  assign busy       = busy_r;
  assign ovf        = ovf_r;

endmodule : output_wrapper_cntrlr

// File: tb/tb_output_wrapper_cntrlr.sv
// Directed bench for output_wrapper_cntrlr with hand-computed expectations.
module tb_output_wrapper_cntrlr;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [31:0] result;
  logic        output_acc;
  logic        output_rdy;
  logic [7:0]  dout;
  logic        outsent;
  logic        busy;
  logic        ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  output_wrapper_cntrlr #(.WORD_W(8), .NWORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .result     (result),
    .output_acc (output_acc),
    .output_rdy (output_rdy),
    .dout       (dout),
    .outsent    (outsent),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fast consumer: one cycle acc high, one cycle low
  task automatic send_word(input string tag, input logic [7:0] exp);
    chk({tag, " rdy"}, {31'd0, output_rdy}, 32'd1);
    chk({tag, " dout"}, {24'd0, dout}, {24'd0, exp});
    chk({tag, " outsent"}, {31'd0, outsent}, 32'd0);
    output_acc = 1'b1;
    tick();
    chk({tag, " rel rdy"}, {31'd0, output_rdy}, 32'd0);
    chk({tag, " rel dout"}, {24'd0, dout}, {24'd0, exp});
    output_acc = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] w1 [4];
    logic [7:0] w2 [4];
    w1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    w2 = '{8'h88, 8'h77, 8'h66, 8'h55};

    // Reset with done held high
    rst = 1'b0; done = 1'b1; result = 32'hDDCCBBAA; output_acc = 1'b0;
    tick(); tick();
    chk("rst rdy", {31'd0, output_rdy}, 32'd0);
    chk("rst outsent", {31'd0, outsent}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ovf", {31'd0, ovf}, 32'd0);
    chk("rst dout", {24'd0, dout}, 32'd0);
    rst = 1'b1; done = 1'b0; output_acc = 1'b1;
    tick(); tick(); tick();
    chk("idle rdy", {31'd0, output_rdy}, 32'd0);
    chk("idle outsent", {31'd0, outsent}, 32'd1);
    output_acc = 1'b0;

    // Single frame, fast consumer
    result = 32'hDDCCBBAA; done = 1'b1;
    tick();
    done = 1'b0;
    chk("f1 busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) send_word("f1", w1[k]);
    chk("f1 end outsent", {31'd0, outsent}, 32'd1);
    chk("f1 end busy", {31'd0, busy}, 32'd0);
    chk("f1 end rdy", {31'd0, output_rdy}, 32'd0);
    chk("f1 ovf", {31'd0, ovf}, 32'd0);

    // Slow consumer: acc after 5 cycles, high for 3
    result = 32'h55667788; done = 1'b1;
    tick();
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); tick(); tick(); tick(); tick();
      chk("slow rdy", {31'd0, output_rdy}, 32'd1);
      chk("slow dout", {24'd0, dout}, {24'd0, w2[k]});
      output_acc = 1'b1;
      tick();
      chk("slow rel rdy", {31'd0, output_rdy}, 32'd0);
      tick(); tick();
      chk("slow hold rdy", {31'd0, output_rdy}, 32'd0);
      chk("slow hold dout", {24'd0, dout}, {24'd0, w2[k]});
      chk("slow hold outsent", {31'd0, outsent}, 32'd0);
      output_acc = 1'b0;
      tick();
    end
    chk("slow end outsent", {31'd0, outsent}, 32'd1);

    // Overflow: second done during word 1
    result = 32'h11223344; done = 1'b1;
    tick();
    done = 1'b0;
    send_word("ovf w0", 8'h44);
    result = 32'hFFFFFFFF; done = 1'b1;
    tick();
    done = 1'b0;
    chk("ovf set", {31'd0, ovf}, 32'd1);
    send_word("ovf w1", 8'h33);
    send_word("ovf w2", 8'h22);
    send_word("ovf w3", 8'h11);
    chk("ovf sticky", {31'd0, ovf}, 32'd1);
    chk("ovf end outsent", {31'd0, outsent}, 32'd1);

    // Reset during RELEASE of word 2
    result = 32'h0A0B0C0D; done = 1'b1;
    tick();
    done = 1'b0;
    send_word("mid w0", 8'h0D);
    send_word("mid w1", 8'h0C);
    chk("mid w2 dout", {24'd0, dout}, 32'h0B);
    output_acc = 1'b1;
    tick();
    chk("mid rel rdy", {31'd0, output_rdy}, 32'd0);
    rst = 1'b0;
    tick();
    chk("mid rst outsent", {31'd0, outsent}, 32'd1);
    chk("mid rst rdy", {31'd0, output_rdy}, 32'd0);
    chk("mid rst ovf", {31'd0, ovf}, 32'd0);
    chk("mid rst dout", {24'd0, dout}, 32'd0);
    rst = 1'b1; output_acc = 1'b0;
    tick();
    result = 32'h01020304; done = 1'b1;
    tick();
    done = 1'b0;
    result = 32'hDEADBEEF;
    send_word("new w0", 8'h04);
    send_word("new w1", 8'h03);
    send_word("new w2", 8'h02);
    send_word("new w3", 8'h01);
    chk("new end outsent", {31'd0, outsent}, 32'd1);

    // Back-to-back: done in the first cycle outsent is back to 1
    result = 32'hCAFEBABE; done = 1'b1;
    tick();
    done = 1'b0;
    chk("b2b ovf", {31'd0, ovf}, 32'd0);
    send_word("b2b w0", 8'hBE);
    send_word("b2b w1", 8'hBA);
    send_word("b2b w2", 8'hFE);
    send_word("b2b w3", 8'hCA);
    chk("b2b end outsent", {31'd0, outsent}, 32'd1);
    chk("b2b end ovf", {31'd0, ovf}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_output_wrapper_cntrlr
